coll_map_arbiter: RTL and testbench

- Schedules the per-frame wall-collision check for the player ball against the shared 32x32 tile map RAM.
- Shares that single-port RAM with the renderer's read port.
- On each frame tick it snapshots the ball's proposed next position, reads the four bounding-box corner tiles and produces coll_next for the ball module before the next frame_clk edge.
- Sits between the ball controller, the renderer and the map RAM.

---
 rtl/coll_map_arbiter_pkg.sv | 31 +++
 rtl/coll_map_arbiter_if.sv | 25 ++
 rtl/coll_map_arbiter_rr.sv | 40 ++++
 rtl/coll_map_arbiter.sv | 138 +++++++++++++
 tb/tb_coll_map_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/coll_map_arbiter_pkg.sv
// Shared types and constants for the ball collision / map RAM arbiter.
package coll_pkg;

   localparam int MAP_AW     = 10;
   localparam int TILE_SHIFT = 12;
   localparam int FRAC_BITS  = 7;
   localparam int TILE_BITS  = 5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CALC  = 3'd1,
      ISSUE = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } coll_state_e;

   typedef logic [1:0] corner_idx_t;

   typedef enum logic {
      OWNER_REND = 1'b0,
      OWNER_COLL = 1'b1
   } owner_e;

   // Map address {ty, tx} of a corner; both coordinates are 18-bit 10.7 values
   // whose bit 17 is the out-of-range flag and is not part of the tile index.
   function automatic logic [MAP_AW-1:0] tile_addr(input logic [17:0] cx,
                                                   input logic [17:0] cy);
      return {cy[TILE_SHIFT +: TILE_BITS], cx[TILE_SHIFT +: TILE_BITS]};
   endfunction

endpackage

// File: rtl/coll_map_arbiter_if.sv
// Renderer read port plus map RAM port shared through the arbiter.
// Handshake: the renderer raises rd_req with a stable rd_addr and holds both
// until rd_gnt is seen high in a cycle; rd_valid/rd_data follow one cycle
// after that grant. map_data answers map_addr one cycle later.
interface coll_map_arbiter_if #(
   parameter int TILE_W = 4
) ();
   logic              rd_req;
   logic [9:0]        rd_addr;
   logic              rd_gnt;
   logic              rd_valid;
   logic [TILE_W-1:0] rd_data;
   logic [9:0]        map_addr;
   logic [TILE_W-1:0] map_data;

   modport slave (
      input  rd_req, rd_addr, map_data,
      output rd_gnt, rd_valid, rd_data, map_addr
   );

   modport master (
      output rd_req, rd_addr, map_data,
      input  rd_gnt, rd_valid, rd_data, map_addr
   );
endinterface

// File: rtl/coll_map_arbiter_rr.sv
// Two-requester round-robin grant for the single-port map RAM.
module map_rr_arbiter
   import coll_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              coll_req,
   input  logic [MAP_AW-1:0] coll_addr,
   input  logic              rend_req,
   input  logic [MAP_AW-1:0] rend_addr,
   output logic              coll_gnt,
   output logic              rend_gnt,
   output logic [MAP_AW-1:0] map_addr
);
   owner_e last_owner;

   // Pick one winner per cycle; on contention the side not served last wins.
   always_comb begin
      coll_gnt = 1'b0;
      rend_gnt = 1'b0;
      map_addr = '0;
      if (coll_req && rend_req) begin
         if (last_owner == OWNER_REND) coll_gnt = 1'b1;
         else                          rend_gnt = 1'b1;
      end else if (coll_req) begin
         coll_gnt = 1'b1;
      end else if (rend_req) begin
         rend_gnt = 1'b1;
      end
      if (coll_gnt)      map_addr = coll_addr;
      else if (rend_gnt) map_addr = rend_addr;
   end

   // Remember who was served on every grant.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)      last_owner <= OWNER_REND;
      else if (coll_gnt) last_owner <= OWNER_COLL;
      else if (rend_gnt) last_owner <= OWNER_REND;
   end
endmodule

// File: rtl/coll_map_arbiter.sv
// Per-frame bounding-box wall check for the ball, sharing the map RAM with
// the renderer. Four corner tiles are read; any solid or off-map corner
// blocks the proposed move.
module coll_map_arbiter
   import coll_pkg::*;
#(
   parameter int HALF   = 8,
   parameter int TILE_W = 4
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              frame_tick,
   input  logic [16:0]       X_next,
   input  logic [16:0]       Y_next,
   output logic              coll_next,
   output logic              coll_valid,
   output logic              overrun,
   coll_map_arbiter_if.slave bus,
   output coll_state_e       state_dbg
);
   localparam logic [17:0] CORNER_OFS = 18'(HALF << FRAC_BITS);

   coll_state_e              state, state_nxt;
   logic [16:0]              x_snap, y_snap;
   logic [17:0]              xl, xr, yt, yb;
   logic [3:0][MAP_AW-1:0]   corner_addr;
   logic [3:0]               corner_oob;
   corner_idx_t              k;
   logic                     acc, acc_nxt;
   logic                     coll_gnt_d, oob_d;
   logic                     coll_req, coll_gnt;
   logic                     rend_req, rend_gnt;
   logic                     rd_valid_q;
   logic [MAP_AW-1:0]        map_addr_w;

   // Renderer requests are masked while reset is held so no grant escapes.
   assign rend_req     = bus.rd_req & Reset_n;
   assign bus.rd_gnt   = rend_gnt;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_valid_q ? bus.map_data : '0;
   assign bus.map_addr = map_addr_w;
   assign state_dbg    = state;

   map_rr_arbiter u_arb (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .coll_req  (coll_req),
      .coll_addr (corner_addr[k]),
      .rend_req  (rend_req),
      .rend_addr (bus.rd_addr),
      .coll_gnt  (coll_gnt),
      .rend_gnt  (rend_gnt),
      .map_addr  (map_addr_w)
   );

   // Corner coordinates with one guard bit: bit 17 flags under/overflow.
   always_comb begin
      xl = {1'b0, x_snap} - CORNER_OFS;
      xr = {1'b0, x_snap} + CORNER_OFS;
      yt = {1'b0, y_snap} - CORNER_OFS;
      yb = {1'b0, y_snap} + CORNER_OFS;
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; the FSM only requests the RAM while in ISSUE.
   always_comb begin
      state_nxt = state;
      coll_req  = 1'b0;
      unique case (state)
         IDLE:  if (frame_tick) state_nxt = CALC;
         CALC:  state_nxt = ISSUE;
         ISSUE: begin
            coll_req = 1'b1;
            if (coll_gnt && k == 2'd3) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture corner tile addresses and off-map flags once per check.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         corner_addr <= '0;
         corner_oob  <= '0;
      end else if (state == CALC) begin
         corner_addr[0] <= tile_addr(xl, yt);
         corner_addr[1] <= tile_addr(xr, yt);
         corner_addr[2] <= tile_addr(xl, yb);
         corner_addr[3] <= tile_addr(xr, yb);
         corner_oob     <= {xr[17] | yb[17], xl[17] | yb[17],
                            xr[17] | yt[17], xl[17] | yt[17]};
      end
   end

   // Solid accumulator: cleared on an accepted tick, then ORs in each
   // corner's result the cycle its RAM data returns.
   always_comb begin
      if (state == IDLE && frame_tick) acc_nxt = 1'b0;
      else acc_nxt = acc | (coll_gnt_d & (oob_d | (|bus.map_data)));
   end

   // Snapshots, corner counter, result and status registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x_snap     <= '0;
         y_snap     <= '0;
         k          <= '0;
         acc        <= 1'b0;
         coll_gnt_d <= 1'b0;
         oob_d      <= 1'b0;
         coll_next  <= 1'b1;
         coll_valid <= 1'b0;
         overrun    <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         coll_gnt_d <= coll_gnt;
         oob_d      <= corner_oob[k];
         acc        <= acc_nxt;
         coll_valid <= (state == DRAIN);
         rd_valid_q <= rend_gnt;
         if (state == IDLE && frame_tick) begin
            x_snap <= X_next;
            y_snap <= Y_next;
         end
         if (state == CALC)  k <= '0;
         else if (coll_gnt)  k <= k + 2'd1;
         if (state == DRAIN) coll_next <= acc_nxt;
         if (frame_tick && state != IDLE) overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_coll_map_arbiter.sv
// Randomized bench for coll_map_arbiter with a reference model of the
// corner check and the round-robin sharing of the map RAM.
module tb_coll_map_arbiter;
   import coll_pkg::*;

   localparam int TILE_W = 4;
   localparam int OFS    = 8 * 128;
   localparam int LIM    = 131072;

   logic        Clk        = 1'b0;
   logic        Reset_n    = 1'b0;
   logic        frame_tick = 1'b0;
   logic [16:0] X_next     = '0;
   logic [16:0] Y_next     = '0;
   logic        coll_next, coll_valid, overrun;
   coll_state_e state_dbg;

   coll_map_arbiter_if #(.TILE_W(TILE_W)) bus ();

   coll_map_arbiter #(.HALF(8), .TILE_W(TILE_W)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .frame_tick (frame_tick),
      .X_next     (X_next),
      .Y_next     (Y_next),
      .coll_next  (coll_next),
      .coll_valid (coll_valid),
      .overrun    (overrun),
      .bus        (bus),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock / reset / RAM ----------------
   int cyc = 0;
   initial forever #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   logic [TILE_W-1:0] mem [1024];
   always @(posedge Clk) bus.map_data <= mem[bus.map_addr];

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   logic              coll_val_q [$];
   int                coll_cyc_q [$];
   logic [TILE_W-1:0] rd_q [$];

   bit m_busy, m_last_ren, m_overrun, m_coll, m_hit, ovr_set;
   int m_start, m_grants, m_done;
   int m_addr [4];
   bit m_oob  [4];
   bit gnt_seen = 1'b0;
   int ren_rate = 0;
   bit ren_fixed = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   function automatic int tile_of(input int v);
      int m;
      m = (v + 262144) % 262144;
      return (m / 4096) % 32;
   endfunction

   // ---------------- monitor + reference model ----------------
   always @(negedge Clk) begin
      bit exp_cv, creq, rreq, cw, rw;
      logic [TILE_W-1:0] e;
      gnt_seen = bus.rd_gnt;
      if (!Reset_n) begin
         m_busy = 0; m_last_ren = 1; m_overrun = 0; m_coll = 1;
         coll_val_q.delete(); coll_cyc_q.delete(); rd_q.delete();
         chk("rst_coll_next",  int'(coll_next),    1);
         chk("rst_coll_valid", int'(coll_valid),   0);
         chk("rst_overrun",    int'(overrun),      0);
         chk("rst_rd_gnt",     int'(bus.rd_gnt),   0);
         chk("rst_rd_valid",   int'(bus.rd_valid), 0);
         chk("rst_rd_data",    int'(bus.rd_data),  0);
         chk("rst_map_addr",   int'(bus.map_addr), 0);
         chk("rst_state",      int'(state_dbg),    int'(IDLE));
      end else begin
         // registered outputs for this cycle
         exp_cv = (coll_cyc_q.size() > 0) && (coll_cyc_q[0] == cyc);
         chk("coll_valid", int'(coll_valid), int'(exp_cv));
         if (exp_cv) begin
            m_coll = coll_val_q.pop_front();
            void'(coll_cyc_q.pop_front());
         end
         chk("coll_next", int'(coll_next), int'(m_coll));
         chk("overrun", int'(overrun), int'(m_overrun));
         chk("rd_valid", int'(bus.rd_valid), int'(rd_q.size() > 0));
         if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk("rd_data", int'(bus.rd_data), int'(e));
         end

         // frame tick
         ovr_set = 0;
         if (frame_tick) begin
            if (m_busy) ovr_set = 1;
            else begin
               m_busy = 1; m_start = cyc; m_grants = 0; m_hit = 0; m_done = -1;
               for (int i = 0; i < 4; i++) begin
                  int cx, cy;
                  cx = (i % 2 == 1) ? int'(X_next) + OFS : int'(X_next) - OFS;
                  cy = (i >= 2)     ? int'(Y_next) + OFS : int'(Y_next) - OFS;
                  m_oob[i]  = (cx < 0) || (cx >= LIM) || (cy < 0) || (cy >= LIM);
                  m_addr[i] = tile_of(cy) * 32 + tile_of(cx);
               end
            end
         end
         if (m_busy && cyc == m_done) m_busy = 0;

         // one RAM grant per cycle, alternating under contention
         creq = m_busy && (m_grants < 4) && (cyc >= m_start + 2);
         rreq = bus.rd_req;
         cw = creq && (!rreq || m_last_ren);
         rw = rreq && !cw;
         chk("rd_gnt", int'(bus.rd_gnt), int'(rw));
         if (cw) chk("map_addr_coll", int'(bus.map_addr), m_addr[m_grants]);
         if (rw) begin
            chk("map_addr_rend", int'(bus.map_addr), int'(bus.rd_addr));
            rd_q.push_back(mem[bus.rd_addr]);
            m_last_ren = 1;
         end
         if (cw) begin
            m_hit = m_hit | m_oob[m_grants] | (mem[m_addr[m_grants]] != '0);
            m_grants++;
            m_last_ren = 0;
            if (m_grants == 4) begin
               m_done = cyc + 2;
               coll_val_q.push_back(m_hit);
               coll_cyc_q.push_back(m_done);
            end
         end
         m_overrun = m_overrun | ovr_set;
      end
   end

   // ---------------- renderer driver ----------------
   initial begin
      bus.rd_req  = 1'b0;
      bus.rd_addr = '0;
      forever begin
         @(posedge Clk); #1;
         if (!Reset_n) bus.rd_req = 1'b0;
         else if (!bus.rd_req || gnt_seen) begin
            bus.rd_req  = ($urandom_range(99) < ren_rate);
            bus.rd_addr = ren_fixed ? 10'd500 : 10'($urandom_range(1023));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge Clk); #1;
      end
   endtask

   task automatic pulse_tick(input logic [16:0] x, input logic [16:0] y);
      frame_tick = 1'b1;
      X_next = x;
      Y_next = y;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic clear_map();
      for (int i = 0; i < 1024; i++) mem[i] = '0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      clear_map();
      step(3);
      Reset_n = 1'b1;
      step(2);

      // centre of screen, empty map
      pulse_tick(17'h0A000, 17'h07800);
      step(11);
      // one solid corner tile, then cleared again
      mem[234] = 4'h3;
      pulse_tick(17'h0A000, 17'h07800);
      step(11);
      mem[234] = '0;
      pulse_tick(17'h0A000, 17'h07800);
      step(11);
      // left corners off the map
      pulse_tick(17'h00200, 17'h07800);
      step(11);
      // bottom-right corner off the map
      pulse_tick(17'h1FF00, 17'h1FF00);
      step(11);

      // renderer hammering one address during a check
      mem[500]  = 4'h5;
      ren_fixed = 1'b1;
      ren_rate  = 100;
      step(2);
      pulse_tick(17'h0A000, 17'h07800);
      step(15);
      ren_rate = 0;
      step(4);
      ren_fixed = 1'b0;
      mem[500]  = '0;

      // second tick while busy
      pulse_tick(17'h0A000, 17'h07800);
      step(2);
      pulse_tick(17'h0A000, 17'h07800);
      step(12);

      // reset in the middle of a check, then a clean check
      pulse_tick(17'h0A000, 17'h07800);
      step(3);
      Reset_n = 1'b0;
      step(2);
      Reset_n = 1'b1;
      step(1);
      pulse_tick(17'h0A000, 17'h07800);
      step(11);

      // randomized frames, maps and renderer traffic
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(99) < 4) ? 4'($urandom_range(15, 1)) : 4'h0;
         ren_rate = $urandom_range(100);
         if ($urandom_range(1) == 1)
            pulse_tick(17'($urandom_range(131071)), 17'($urandom_range(131071)));
         else
            pulse_tick(17'($urandom_range(70000, 60000)), 17'($urandom_range(70000, 60000)));
         step($urandom_range(14, 3));
      end

      ren_rate = 0;
      step(30);
      chk("coll_pending_at_end", coll_val_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
